// File: rtl/axi_wr_data_gen_if.sv
// AXI write-data channel bundle between the write-data generator and the slave.
interface axi_wr_data_gen_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;

  modport master (
    output m_axi_wdata,
    output m_axi_wstrb,
    output m_axi_wlast,
    output m_axi_wvalid,
    input  m_axi_wready
  );

  modport slave (
    input  m_axi_wdata,
    input  m_axi_wstrb,
    input  m_axi_wlast,
    input  m_axi_wvalid,
    output m_axi_wready
  );
endinterface

// File: rtl/axi_wr_data_gen.sv
// Write-data generator: streams a seeded incrementing word pattern on the AXI
// W channel for a whole job, with burst-aligned wlast and lane-correct strobes.
module axi_wr_data_gen #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   engine_start,
  input  logic [39:0]            total_beat_count,
  input  logic [7:0]             wr_len,
  input  logic [2:0]             wr_size,
  input  logic [31:0]            wr_init_data,
  axi_wr_data_gen_if.master      w,
  output logic                   data_done,
  output logic [39:0]            beats_sent
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LOFF_W = $clog2(STRB_W);
  localparam int LANES  = DATA_WIDTH / 32;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t              state;
  state_t              state_next;
  logic [39:0]         remaining;
  logic [7:0]          bcnt;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [31:0]         init_q;
  logic [LOFF_W-1:0]   loff;
  logic [31:0]         word;
  logic                accept;
  logic                last_accept;

  // Byte-lane mask for one beat of 2^size bytes starting at lane offset off.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] size,
                                                  input logic [LOFF_W-1:0] off);
    int bytes;
    int base;
    lane_strb = '0;
    bytes = 1 << size;
    base  = int'(off);
    if (bytes >= STRB_W) begin
      lane_strb = '1;
    end else begin
      for (int i = 0; i < STRB_W; i++) begin
        lane_strb[i] = (i >= base) && (i < base + bytes);
      end
    end
  endfunction

  // Next lane offset; wide sizes add a multiple of the bus width and stay at 0.
  function automatic logic [LOFF_W-1:0] next_loff(input logic [2:0] size,
                                                  input logic [LOFF_W-1:0] off);
    int sum;
    sum = int'(off) + (1 << size);
    return sum[LOFF_W-1:0];
  endfunction

  assign accept      = (state == SEND) && w.m_axi_wready;
  assign last_accept = accept && (remaining == 40'd1);
  assign word        = init_q + beats_sent[31:0];

  // Control state: FSM register, completion pulse and accepted-beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      data_done  <= 1'b0;
      beats_sent <= '0;
    end else begin
      state     <= state_next;
      data_done <= ((state == LOAD) && (total_beat_count == 40'd0)) || last_accept;
      if (state == LOAD) begin
        beats_sent <= '0;
      end else if (accept) begin
        beats_sent <= beats_sent + 40'd1;
      end
    end
  end

  // Job parameters and per-beat position (remaining, burst counter, lane offset).
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      remaining <= total_beat_count;
      len_q     <= wr_len;
      size_q    <= wr_size;
      init_q    <= wr_init_data;
      bcnt      <= '0;
      loff      <= '0;
    end else if (accept) begin
      remaining <= remaining - 40'd1;
      bcnt      <= (bcnt == len_q) ? 8'd0 : bcnt + 8'd1;
      loff      <= next_loff(size_q, loff);
    end
  end

  // Next-state logic; a start outside IDLE is ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (engine_start) state_next = LOAD;
      LOAD:    state_next = (total_beat_count == 40'd0) ? IDLE : SEND;
      SEND:    if (last_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // W channel outputs, derived from held state so they are stable under stall.
  always_comb begin
    w.m_axi_wvalid = 1'b0;
    w.m_axi_wdata  = '0;
    w.m_axi_wstrb  = '0;
    w.m_axi_wlast  = 1'b0;
    if (state == SEND) begin
      w.m_axi_wvalid = 1'b1;
      w.m_axi_wdata  = {LANES{word}};
      w.m_axi_wstrb  = lane_strb(size_q, loff);
      w.m_axi_wlast  = (bcnt == len_q);
    end
  end

endmodule

// File: tb/tb_axi_wr_data_gen.sv
// Self-checking bench for axi_wr_data_gen: directed jobs from the test plan
// plus randomized jobs, all checked against a per-beat formula model.
module tb_axi_wr_data_gen;

  localparam int DW = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        engine_start;
  logic [39:0] total_beat_count;
  logic [7:0]  wr_len;
  logic [2:0]  wr_size;
  logic [31:0] wr_init_data;
  logic        data_done;
  logic [39:0] beats_sent;

  int n_checks = 0;
  int n_errors = 0;

  axi_wr_data_gen_if #(.DATA_WIDTH(DW)) w_if ();

  axi_wr_data_gen #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .engine_start     (engine_start),
    .total_beat_count (total_beat_count),
    .wr_len           (wr_len),
    .wr_size          (wr_size),
    .wr_init_data     (wr_init_data),
    .w                (w_if),
    .data_done        (data_done),
    .beats_sent       (beats_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job. rmode: 0 ready always, 1 ready alternating, 2 ready random.
  // poke: pulse engine_start during SEND (including the final accept).
  // abort_at >= 0: assert reset once that many beats have been accepted.
  task automatic run_job(input int total, input int len, input int size,
                         input logic [31:0] init, input int rmode,
                         input bit poke, input int abort_at);
    int k;
    int bytes;
    int off;
    bit done_seen;
    bit rdy;
    logic [31:0]  word;
    logic [511:0] exp_data;
    logic [63:0]  exp_strb;
    logic         exp_last;

    wr_len           = 8'(len);
    wr_size          = 3'(size);
    wr_init_data     = init;
    total_beat_count = 40'h5A5A5A5A5A;
    engine_start     = 1'b1;
    step();
    engine_start     = 1'b0;
    total_beat_count = 40'(total);
    check("load_wvalid", 512'(w_if.m_axi_wvalid), 512'(0));
    step();

    k = 0;
    done_seen = 1'b0;
    bytes = 1 << size;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      if (k == total) begin
        check("end_wvalid", 512'(w_if.m_axi_wvalid), 512'(0));
        check("end_data_done", 512'(data_done), 512'(1));
        check("end_beats_sent", 512'(beats_sent), 512'(total));
        done_seen = 1'b1;
      end else if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        w_if.m_axi_wready = 1'b1;
        step();
        check("rst_wvalid", 512'(w_if.m_axi_wvalid), 512'(0));
        check("rst_wdata", w_if.m_axi_wdata, 512'(0));
        check("rst_wstrb", 512'(w_if.m_axi_wstrb), 512'(0));
        check("rst_wlast", 512'(w_if.m_axi_wlast), 512'(0));
        check("rst_beats_sent", 512'(beats_sent), 512'(0));
        check("rst_data_done", 512'(data_done), 512'(0));
        reset = 1'b0;
        step();
        check("post_rst_data_done", 512'(data_done), 512'(0));
        check("post_rst_wvalid", 512'(w_if.m_axi_wvalid), 512'(0));
        return;
      end else begin
        word = init + 32'(k);
        for (int l = 0; l < DW / 32; l++) exp_data[l*32 +: 32] = word;
        off = (k * bytes) % (DW / 8);
        if (bytes >= DW / 8) exp_strb = '1;
        else exp_strb = ((64'd1 << bytes) - 64'd1) << off;
        exp_last = ((k % (len + 1)) == len);
        check($sformatf("b%0d_wvalid", k), 512'(w_if.m_axi_wvalid), 512'(1));
        check($sformatf("b%0d_wdata", k), w_if.m_axi_wdata, exp_data);
        check($sformatf("b%0d_wstrb", k), 512'(w_if.m_axi_wstrb), 512'(exp_strb));
        check($sformatf("b%0d_wlast", k), 512'(w_if.m_axi_wlast), 512'(exp_last));
        check($sformatf("b%0d_done", k), 512'(data_done), 512'(0));
        check($sformatf("b%0d_beats_sent", k), 512'(beats_sent), 512'(k));
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        w_if.m_axi_wready = rdy;
        engine_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        if (poke && rdy && k == total - 1) engine_start = 1'b1;
        if (rdy) k++;
      end
      if (!done_seen) step();
    end
    check("job_completed", 512'(done_seen), 512'(1));

    engine_start = 1'b0;
    w_if.m_axi_wready = 1'b0;
    step();
    check("idle_wvalid", 512'(w_if.m_axi_wvalid), 512'(0));
    check("idle_data_done", 512'(data_done), 512'(0));
  endtask

  initial begin
    reset             = 1'b1;
    engine_start      = 1'b0;
    total_beat_count  = '0;
    wr_len            = '0;
    wr_size           = '0;
    wr_init_data      = '0;
    w_if.m_axi_wready = 1'b0;
    repeat (3) step();
    check("reset_wvalid", 512'(w_if.m_axi_wvalid), 512'(0));
    check("reset_wlast", 512'(w_if.m_axi_wlast), 512'(0));
    check("reset_wstrb", 512'(w_if.m_axi_wstrb), 512'(0));
    check("reset_wdata", w_if.m_axi_wdata, 512'(0));
    check("reset_data_done", 512'(data_done), 512'(0));
    check("reset_beats_sent", 512'(beats_sent), 512'(0));
    reset = 1'b0;
    step();

    run_job(8, 3, 6, 32'h100, 0, 1'b0, -1);
    run_job(8, 3, 6, 32'h100, 1, 1'b0, -1);
    run_job(8, 7, 4, 32'hA000_0000, 0, 1'b0, -1);
    run_job(6, 3, 6, 32'hFFFF_FFFE, 0, 1'b0, -1);
    run_job(0, 3, 6, 32'h1, 0, 1'b0, -1);
    run_job(10, 2, 5, 32'h55, 2, 1'b1, -1);
    run_job(8, 3, 6, 32'h200, 0, 1'b0, 3);
    run_job(8, 3, 6, 32'h300, 0, 1'b0, -1);
    run_job(9, 0, 2, 32'h7, 2, 1'b0, -1);

    for (int j = 0; j < 12; j++) begin
      run_job($urandom_range(1, 30), $urandom_range(0, 9), $urandom_range(0, 7),
              $urandom, 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
